demux_route_ctrl: RTL
=====================

# demux_route_ctrl

Sequencer that generates the 2-bit steering token stream (`[1]` valid, `[0]` direction: 0 = left, 1 = right) consumed by the `go_right` input of the dataflow demux. It splits the data stream into programmable bursts: L tokens to the left path, then R tokens to the right path, repeating. It obeys the back-stop handshake and optionally keeps per-side counts of accepted tokens.

## Interface
- `CW`, 8: width of the burst-length fields.
- `SW`, 16: width of the statistics counters.
- `DEF_LEFT`, 1: left burst length loaded at reset.
- `DEF_RIGHT`, 1: right burst length loaded at reset.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `en`  in  1  run enable.
- `cfg_load`  in  1  single-cycle request to load new burst lengths.
- `left_burst_in`  in  CW  new left burst length.
- `right_burst_in`  in  CW  new right burst length.
- `go_right`  out  2  steering token to the demux.
- `go_right_back_stop`  in  1  demux stall; the token is not consumed while high.
- `cfg_busy`  out  1  a configuration is pending and not yet applied.
- `left_count`  out  SW  accepted left tokens, wraps.
- `right_count`  out  SW  accepted right tokens, wraps.

## Operation
- Accept: `go_right[1] && !go_right_back_stop` at a rising edge.
- Boundary cycle: a cycle in which `go_right[1]` is low, or the current token is accepted.
- Registers:
  - `lb`, `rb`: active burst lengths.
  - `rem`: tokens remaining in the current burst.
  - `pend_l`, `pend_r`, `pend`: pending configuration.
  - State: IDLE, LEFT, RIGHT.
- Outputs:
  - `go_right[1]` = (state != IDLE).
  - `go_right[0]` = (state == RIGHT).
  - Both are decoded from registers only. There is no combinational path from any input.
- Token stability: while valid and stalled, direction is held and valid stays high. `en` and configuration changes take effect only at a boundary cycle.
- Start sequence (used at start and restart):
  - LEFT with `rem = lb` if `lb != 0`.
  - Else RIGHT with `rem = rb` if `rb != 0`.
  - Else IDLE.
- IDLE: if `en` and not (`lb == 0 && rb == 0`), run the start sequence.
- LEFT/RIGHT on accept:
  - If `rem > 1`: decrement `rem`.
  - If `rem == 1`: switch to the other side if its length is nonzero, else reload the same side. `rem` is loaded with the new side's length.
- `en` low at a boundary cycle → IDLE. The current token still completes first.
- Configuration:
  - `cfg_load` captures `left_burst_in`/`right_burst_in` into `pend_l`/`pend_r` and sets `pend`.
  - A later `cfg_load` overwrites pending values.
  - At the first boundary cycle with `pend` set (including the load cycle itself): `lb`/`rb` ← pending, `pend` cleared. If `en`, the start sequence runs with the new lengths; otherwise state → IDLE.
  - Configuration wins over normal burst advance in the same cycle.
  - A token accepted in that same cycle is still counted.
- `cfg_busy` = `pend`.
- Counters: `left_count` / `right_count` increment by 1 on each accepted left/right token. They wrap modulo 2^SW.
- Widths: `rem` is CW bits. Burst lengths of 1 to 2^CW−1 are valid; 0 disables that side.

## Timing
- Reset (async assert, sync-safe deassert):
  - `go_right` = 2'b00, state IDLE, `cfg_busy` = 0, counts = 0.
  - `lb` = DEF_LEFT, `rb` = DEF_RIGHT, `rem` = 0.
- `rst_n` low mid-burst: outputs drop immediately and the burst position is lost.
- Latency:
  - `en` sampled high at edge k → first valid token after edge k.
  - `cfg_load` at edge k with no stall → new sequence visible after edge k.
- Throughput: one token per cycle with no stall. The switch between sides costs no bubble.
- Counts are updated at the accepting edge and visible the following cycle.

## Configuration
- `DEMUX_ROUTE_CTRL_STATS_EN` defined: `left_count`/`right_count` are implemented as described above.
- Not defined: no counter registers; both outputs are tied to 0. All other behaviour is identical.

## Test plan
- Reset, `lb`=3, `rb`=2, `en`=1, back-stop low → directions L,L,L,R,R,L,L,L… one per cycle. After 10 accepts: `left_count`=6, `right_count`=4.
- Back-stop held high 4 cycles on the second left token → `go_right` held at 2'b10 unchanged. The sequence resumes exactly where it stopped.
- `cfg_load`(1,0) issued while a token is stalled → `cfg_busy`=1 until accept. After that, all tokens are left (2'b10) and `rb` is ignored.
- `cfg_load`(0,0) → `go_right`=2'b00 after the boundary, even with `en`=1. A later `cfg_load`(2,2) restarts with L,L,R,R.
- `en` dropped during a stall → token held until accepted, then `go_right`=2'b00. `rst_n` pulsed low mid-burst → immediate 2'b00, counts 0.
- With `DEMUX_ROUTE_CTRL_STATS_EN` on and SW=4: 17 left accepts → `left_count`=1 (wrap). With the macro off → counts stay 0.

Source files
------------

// File: rtl/demux_route_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_route_ctrl                                                           |
// | Burst sequencer driving the 2-bit steering token (valid, right) of a demux.|
// | Optional per-side accept counters: define DEMUX_ROUTE_CTRL_STATS_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_route_ctrl #(
   parameter int CW        = 8,
   parameter int SW        = 16,
   parameter int DEF_LEFT  = 1,
   parameter int DEF_RIGHT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          cfg_load,
   input  logic [CW-1:0] left_burst_in,
   input  logic [CW-1:0] right_burst_in,
   output logic [1:0]    go_right,
   input  logic          go_right_back_stop,
   output logic          cfg_busy,
   output logic [SW-1:0] left_count,
   output logic [SW-1:0] right_count
);

   localparam logic [1:0]    c_idle  = 2'd0;
   localparam logic [1:0]    c_left  = 2'd1;
   localparam logic [1:0]    c_right = 2'd2;
   localparam logic [CW-1:0] c_one   = {{(CW-1){1'b0}}, 1'b1};

   logic [1:0]    r_state;
   logic [CW-1:0] r_rem;
   logic [CW-1:0] r_lb;
   logic [CW-1:0] r_rb;
   logic [CW-1:0] r_pend_l;
   logic [CW-1:0] r_pend_r;
   logic          r_pend;

   logic [1:0]    w_state_nxt;
   logic [CW-1:0] w_rem_nxt;
   logic [CW-1:0] w_lb_nxt;
   logic [CW-1:0] w_rb_nxt;
   logic [CW-1:0] w_pend_l_nxt;
   logic [CW-1:0] w_pend_r_nxt;
   logic          w_pend_nxt;

   logic          w_valid;
   logic          w_accept;
   logic          w_boundary;
   logic          w_cfg_now;
   logic [CW-1:0] w_cfg_l;
   logic [CW-1:0] w_cfg_r;

   function automatic logic [1:0] start_state(input logic [CW-1:0] l, input logic [CW-1:0] r);
      if (l != '0)
         return c_left;
      else if (r != '0)
         return c_right;
      else
         return c_idle;
   endfunction

   // With both lengths zero this yields r == 0, matching the idle remainder.
   function automatic logic [CW-1:0] start_rem(input logic [CW-1:0] l, input logic [CW-1:0] r);
      return (l != '0) ? l : r;
   endfunction

   assign w_valid    = (r_state != c_idle);
   assign w_accept   = w_valid && !go_right_back_stop;
   assign w_boundary = !w_valid || w_accept;
   assign w_cfg_now  = r_pend || cfg_load;
   assign w_cfg_l    = cfg_load ? left_burst_in  : r_pend_l;
   assign w_cfg_r    = cfg_load ? right_burst_in : r_pend_r;

   always_comb begin
      w_state_nxt  = r_state;
      w_rem_nxt    = r_rem;
      w_lb_nxt     = r_lb;
      w_rb_nxt     = r_rb;
      w_pend_l_nxt = r_pend_l;
      w_pend_r_nxt = r_pend_r;
      w_pend_nxt   = r_pend;

      if (cfg_load) begin
         w_pend_l_nxt = left_burst_in;
         w_pend_r_nxt = right_burst_in;
         w_pend_nxt   = 1'b1;
      end

      // Nothing moves while a valid token is stalled; only pending config is captured.
      if (w_boundary) begin
         if (w_cfg_now) begin
            w_lb_nxt   = w_cfg_l;
            w_rb_nxt   = w_cfg_r;
            w_pend_nxt = 1'b0;
            if (en) begin
               w_state_nxt = start_state(w_cfg_l, w_cfg_r);
               w_rem_nxt   = start_rem(w_cfg_l, w_cfg_r);
            end else begin
               w_state_nxt = c_idle;
               w_rem_nxt   = '0;
            end
         end else if (!en) begin
            w_state_nxt = c_idle;
            w_rem_nxt   = '0;
         end else if (r_state == c_idle) begin
            w_state_nxt = start_state(r_lb, r_rb);
            w_rem_nxt   = start_rem(r_lb, r_rb);
         end else if (r_rem > c_one) begin
            w_rem_nxt = r_rem - c_one;
         end else if (r_state == c_left) begin
            if (r_rb != '0) begin
               w_state_nxt = c_right;
               w_rem_nxt   = r_rb;
            end else begin
               w_state_nxt = c_left;
               w_rem_nxt   = r_lb;
            end
         end else begin
            if (r_lb != '0) begin
               w_state_nxt = c_left;
               w_rem_nxt   = r_lb;
            end else begin
               w_state_nxt = c_right;
               w_rem_nxt   = r_rb;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_idle;
         r_rem    <= '0;
         r_lb     <= CW'(DEF_LEFT);
         r_rb     <= CW'(DEF_RIGHT);
         r_pend_l <= '0;
         r_pend_r <= '0;
         r_pend   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rem    <= w_rem_nxt;
         r_lb     <= w_lb_nxt;
         r_rb     <= w_rb_nxt;
         r_pend_l <= w_pend_l_nxt;
         r_pend_r <= w_pend_r_nxt;
         r_pend   <= w_pend_nxt;
      end
   end

   assign go_right = {(r_state != c_idle), (r_state == c_right)};
   assign cfg_busy = r_pend;

`ifdef DEMUX_ROUTE_CTRL_STATS_EN
   localparam logic [SW-1:0] c_cnt_one = {{(SW-1){1'b0}}, 1'b1};

   logic [SW-1:0] r_left_count;
   logic [SW-1:0] r_right_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_left_count  <= '0;
         r_right_count <= '0;
      end else if (w_accept) begin
         if (r_state == c_left)
            r_left_count <= r_left_count + c_cnt_one;
         else
            r_right_count <= r_right_count + c_cnt_one;
      end
   end

   assign left_count  = r_left_count;
   assign right_count = r_right_count;
`else
   assign left_count  = '0;
   assign right_count = '0;
`endif

endmodule
`default_nettype wire
